// File: rtl/cmd_chan_dispatch.sv
// Command channel dispatcher: routes latency-adjusted commands to subchannel A, B or both,
// each with its own FIFO and inter-command gap timer. Optional parity: CMD_DISPATCH_PARITY_EN.

module cmd_chan_subchan #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 1,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  par,
    output logic                  valid,
    input  logic                  ready,
    output logic [LVL_W-1:0]      level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam bit         GAP_EN   = (MIN_GAP > 0);
    localparam logic [3:0] GAP_LOAD = 4'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [0:0]            state;
    logic [3:0]            gap_cnt;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = !empty && (state == ST_READY);
    assign do_push = push && !full;
    assign do_pop  = valid && ready;
    assign data    = mem[rd_ptr[AW-1:0]];
    assign level   = LVL_W'(wr_ptr - rd_ptr);

`ifdef CMD_DISPATCH_PARITY_EN
    assign par = ^data;
`else
    assign par = 1'b0;
`endif

    // Storage is cleared on reset so the output word reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // HOLD lasts MIN_GAP cycles: load MIN_GAP-1, leave on the edge after reaching zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_READY;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_READY: begin
                    if (do_pop && GAP_EN) begin
                        state   <= ST_HOLD;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                default: begin
                    if (gap_cnt == 4'd0) begin
                        state <= ST_READY;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

module cmd_chan_dispatch #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 1,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] cmd_in_data,
    input  logic                  cmd_in_valid,
    output logic                  cmd_in_ready,
    output logic [DATA_WIDTH-1:0] cha_data,
    output logic                  cha_par,
    output logic                  cha_valid,
    input  logic                  cha_ready,
    output logic [LVL_W-1:0]      cha_level,
    output logic [DATA_WIDTH-1:0] chb_data,
    output logic                  chb_par,
    output logic                  chb_valid,
    input  logic                  chb_ready,
    output logic [LVL_W-1:0]      chb_level,
    output logic [7:0]            bcast_cnt
);

    logic accept;
    logic is_bcast;
    logic sel_b;
    logic push_a;
    logic push_b;
    logic full_a;
    logic full_b;

    // Ready looks only at fullness so a broadcast can always land in both FIFOs atomically.
    assign cmd_in_ready = !full_a && !full_b;
    assign accept       = cmd_in_valid && cmd_in_ready;
    assign is_bcast     = cmd_in_data[DATA_WIDTH-2];
    assign sel_b        = cmd_in_data[DATA_WIDTH-1];
    assign push_a       = accept && (is_bcast || !sel_b);
    assign push_b       = accept && (is_bcast || sel_b);

    cmd_chan_subchan #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MIN_GAP    (MIN_GAP),
        .LVL_W      (LVL_W)
    ) u_cha (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (cmd_in_data),
        .full      (full_a),
        .data      (cha_data),
        .par       (cha_par),
        .valid     (cha_valid),
        .ready     (cha_ready),
        .level     (cha_level)
    );

    cmd_chan_subchan #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MIN_GAP    (MIN_GAP),
        .LVL_W      (LVL_W)
    ) u_chb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (cmd_in_data),
        .full      (full_b),
        .data      (chb_data),
        .par       (chb_par),
        .valid     (chb_valid),
        .ready     (chb_ready),
        .level     (chb_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcast_cnt <= 8'd0;
        end else if (accept && is_bcast) begin
            bcast_cnt <= bcast_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmd_chan_dispatch.sv
// Directed bench for cmd_chan_dispatch: one instance with MIN_GAP=0, one with MIN_GAP=3.

module tb_cmd_chan_dispatch;

    logic       clk;
    logic       rst_n;

    logic [7:0] cmd_in_data;
    logic       cmd_in_valid;
    logic       cmd_in_ready;
    logic [7:0] cha_data, chb_data;
    logic       cha_par, chb_par, cha_valid, chb_valid;
    logic       cha_ready, chb_ready;
    logic [2:0] cha_level, chb_level;
    logic [7:0] bcast_cnt;

    logic [7:0] g_cmd_in_data;
    logic       g_cmd_in_valid;
    logic       g_cmd_in_ready;
    logic [7:0] g_cha_data, g_chb_data;
    logic       g_cha_par, g_chb_par, g_cha_valid, g_chb_valid;
    logic       g_cha_ready, g_chb_ready;
    logic [2:0] g_cha_level, g_chb_level;
    logic [7:0] g_bcast_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cmd_chan_dispatch #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MIN_GAP(0)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_in_data  (cmd_in_data),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .cha_data     (cha_data),
        .cha_par      (cha_par),
        .cha_valid    (cha_valid),
        .cha_ready    (cha_ready),
        .cha_level    (cha_level),
        .chb_data     (chb_data),
        .chb_par      (chb_par),
        .chb_valid    (chb_valid),
        .chb_ready    (chb_ready),
        .chb_level    (chb_level),
        .bcast_cnt    (bcast_cnt)
    );

    cmd_chan_dispatch #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MIN_GAP(3)) u_gap (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_in_data  (g_cmd_in_data),
        .cmd_in_valid (g_cmd_in_valid),
        .cmd_in_ready (g_cmd_in_ready),
        .cha_data     (g_cha_data),
        .cha_par      (g_cha_par),
        .cha_valid    (g_cha_valid),
        .cha_ready    (g_cha_ready),
        .cha_level    (g_cha_level),
        .chb_data     (g_chb_data),
        .chb_par      (g_chb_par),
        .chb_valid    (g_chb_valid),
        .chb_ready    (g_chb_ready),
        .chb_level    (g_chb_level),
        .bcast_cnt    (g_bcast_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [7:0] d);
`ifdef CMD_DISPATCH_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_in_ready, cha_valid, chb_valid, cha_par, chb_par} !== 5'b10000) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got %b expected 10000",
                     {cmd_in_ready, cha_valid, chb_valid, cha_par, chb_par});
        end
        n_cmp++;
        if ({cha_data, chb_data, bcast_cnt} !== 24'h0) begin
            n_err++;
            $display("[TB] FAIL reset_data: got %h expected 000000", {cha_data, chb_data, bcast_cnt});
        end
        n_cmp++;
        if ({cha_level, chb_level} !== 6'd0) begin
            n_err++;
            $display("[TB] FAIL reset_level: got %h expected 0", {cha_level, chb_level});
        end
        n_cmp++;
        if ({g_cmd_in_ready, g_cha_valid, g_chb_valid} !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL reset_gap_inst: got %b expected 100",
                     {g_cmd_in_ready, g_cha_valid, g_chb_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unicast_a();
        cha_ready = 1'b1;
        chb_ready = 1'b1;
        cmd_in_data = 8'h05;
        cmd_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cha_valid, cha_data, cha_par} !== {1'b1, 8'h05, exp_par(8'h05)}) begin
            n_err++;
            $display("[TB] FAIL unicast_first: got v=%b d=%h p=%b expected v=1 d=05 p=%b",
                     cha_valid, cha_data, cha_par, exp_par(8'h05));
        end
        cmd_in_data = 8'h06;
        @(negedge clk);
        n_cmp++;
        if ({cha_valid, cha_data, cha_level} !== {1'b1, 8'h06, 3'd1}) begin
            n_err++;
            $display("[TB] FAIL unicast_second: got v=%b d=%h lvl=%0d expected v=1 d=06 lvl=1",
                     cha_valid, cha_data, cha_level);
        end
        cmd_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cha_valid, chb_valid, bcast_cnt, cha_level} !== {1'b0, 1'b0, 8'd0, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL unicast_idle: got va=%b vb=%b bc=%0d lvl=%0d expected 0 0 0 0",
                     cha_valid, chb_valid, bcast_cnt, cha_level);
        end
    endtask

    task automatic test_broadcast();
        cmd_in_data = 8'h41;
        cmd_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cha_valid, chb_valid, cha_data, chb_data, bcast_cnt} !== {2'b11, 8'h41, 8'h41, 8'd1}) begin
            n_err++;
            $display("[TB] FAIL bcast_first: got va=%b vb=%b da=%h db=%h bc=%0d expected 1 1 41 41 1",
                     cha_valid, chb_valid, cha_data, chb_data, bcast_cnt);
        end
        n_cmp++;
        if ({cha_par, chb_par} !== {2{exp_par(8'h41)}}) begin
            n_err++;
            $display("[TB] FAIL bcast_par41: got %b%b expected %b%b",
                     cha_par, chb_par, exp_par(8'h41), exp_par(8'h41));
        end
        cmd_in_data = 8'h43;
        @(negedge clk);
        n_cmp++;
        if ({cha_valid, chb_valid, cha_data, chb_data, bcast_cnt} !== {2'b11, 8'h43, 8'h43, 8'd2}) begin
            n_err++;
            $display("[TB] FAIL bcast_second: got va=%b vb=%b da=%h db=%h bc=%0d expected 1 1 43 43 2",
                     cha_valid, chb_valid, cha_data, chb_data, bcast_cnt);
        end
        n_cmp++;
        if ({cha_par, chb_par} !== {2{exp_par(8'h43)}}) begin
            n_err++;
            $display("[TB] FAIL bcast_par43: got %b%b expected %b%b",
                     cha_par, chb_par, exp_par(8'h43), exp_par(8'h43));
        end
        cmd_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cha_valid, chb_valid, cha_level, chb_level} !== {2'b00, 3'd0, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL bcast_drain: got va=%b vb=%b la=%0d lb=%0d expected 0 0 0 0",
                     cha_valid, chb_valid, cha_level, chb_level);
        end
    endtask

    task automatic test_full_backpressure();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h80; exp_q[1] = 8'h80; exp_q[2] = 8'h80; exp_q[3] = 8'h81;
        chb_ready = 1'b0;
        cmd_in_data = 8'h80;
        cmd_in_valid = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({chb_level, cmd_in_ready, chb_valid, chb_data} !== {3'd4, 1'b0, 1'b1, 8'h80}) begin
            n_err++;
            $display("[TB] FAIL full_state: got lvl=%0d rdy=%b v=%b d=%h expected 4 0 1 80",
                     chb_level, cmd_in_ready, chb_valid, chb_data);
        end
        cmd_in_data = 8'h81;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({chb_level, cmd_in_ready} !== {3'd4, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL full_hold: got lvl=%0d rdy=%b expected 4 0", chb_level, cmd_in_ready);
        end
        chb_ready = 1'b1;
        @(negedge clk);
        chb_ready = 1'b0;
        n_cmp++;
        if ({chb_level, cmd_in_ready} !== {3'd3, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL full_release: got lvl=%0d rdy=%b expected 3 1", chb_level, cmd_in_ready);
        end
        @(negedge clk);
        cmd_in_valid = 1'b0;
        n_cmp++;
        if ({chb_level, cmd_in_ready, cha_valid} !== {3'd4, 1'b0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL full_fifth: got lvl=%0d rdy=%b va=%b expected 4 0 0",
                     chb_level, cmd_in_ready, cha_valid);
        end
        chb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({chb_valid, chb_data} !== {1'b1, exp_q[i]}) begin
                n_err++;
                $display("[TB] FAIL full_drain[%0d]: got v=%b d=%h expected v=1 d=%h",
                         i, chb_valid, chb_data, exp_q[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({chb_valid, chb_level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL full_empty: got v=%b lvl=%0d expected 0 0", chb_valid, chb_level);
        end
    endtask

    task automatic test_gap();
        logic       exp_v [11];
        logic [7:0] exp_d [11];
        for (int j = 0; j < 11; j++) begin
            exp_v[j] = (j == 0) || (j == 4) || (j == 8);
            exp_d[j] = 8'h01 + 8'(j / 4);
        end
        g_cha_ready = 1'b0;
        g_cmd_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g_cmd_in_data = 8'h01 + 8'(i);
            @(negedge clk);
        end
        g_cmd_in_valid = 1'b0;
        n_cmp++;
        if ({g_cha_level, g_cha_valid} !== {3'd3, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL gap_preload: got lvl=%0d v=%b expected 3 1", g_cha_level, g_cha_valid);
        end
        g_cha_ready = 1'b1;
        for (int j = 0; j < 11; j++) begin
            n_cmp++;
            if (g_cha_valid !== exp_v[j]) begin
                n_err++;
                $display("[TB] FAIL gap_valid[N+%0d]: got %b expected %b", j, g_cha_valid, exp_v[j]);
            end
            if (exp_v[j]) begin
                n_cmp++;
                if (g_cha_data !== exp_d[j]) begin
                    n_err++;
                    $display("[TB] FAIL gap_data[N+%0d]: got %h expected %h", j, g_cha_data, exp_d[j]);
                end
            end
            @(negedge clk);
        end
        g_cha_ready = 1'b0;
    endtask

    task automatic test_wrap();
        cha_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                n_cmp++;
                if ({cha_valid, cha_data} !== {1'b1, 8'h10 + 8'(i - 1)}) begin
                    n_err++;
                    $display("[TB] FAIL wrap_data[%0d]: got v=%b d=%h expected v=1 d=%h",
                             i - 1, cha_valid, cha_data, 8'h10 + 8'(i - 1));
                end
                n_cmp++;
                if (cha_level !== 3'd1) begin
                    n_err++;
                    $display("[TB] FAIL wrap_level[%0d]: got %0d expected 1", i - 1, cha_level);
                end
            end
            if (i < 20) begin
                cmd_in_data = 8'h10 + 8'(i);
                cmd_in_valid = 1'b1;
            end else begin
                cmd_in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({cha_valid, cha_level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL wrap_end: got v=%b lvl=%0d expected 0 0", cha_valid, cha_level);
        end
    endtask

    task automatic test_reset_mid();
        chb_ready = 1'b0;
        cmd_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_in_data = 8'h90 + 8'(i);
            @(negedge clk);
        end
        cmd_in_valid = 1'b0;
        n_cmp++;
        if ({chb_level, bcast_cnt} !== {3'd3, 8'd2}) begin
            n_err++;
            $display("[TB] FAIL rstmid_pre: got lvl=%0d bc=%0d expected 3 2", chb_level, bcast_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({chb_level, chb_valid, chb_data, bcast_cnt, cmd_in_ready} !== {3'd0, 1'b0, 8'h00, 8'd0, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL rstmid_now: got lvl=%0d v=%b d=%h bc=%0d rdy=%b expected 0 0 00 0 1",
                     chb_level, chb_valid, chb_data, bcast_cnt, cmd_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chb_ready = 1'b1;
        cmd_in_data = 8'h95;
        cmd_in_valid = 1'b1;
        @(negedge clk);
        cmd_in_valid = 1'b0;
        n_cmp++;
        if ({chb_valid, chb_data, chb_level} !== {1'b1, 8'h95, 3'd1}) begin
            n_err++;
            $display("[TB] FAIL rstmid_first: got v=%b d=%h lvl=%0d expected 1 95 1",
                     chb_valid, chb_data, chb_level);
        end
        @(negedge clk);
        n_cmp++;
        if ({chb_valid, chb_level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL rstmid_drain: got v=%b lvl=%0d expected 0 0", chb_valid, chb_level);
        end
    endtask

    initial begin
        cmd_in_data    = 8'h00;
        cmd_in_valid   = 1'b0;
        cha_ready      = 1'b0;
        chb_ready      = 1'b0;
        g_cmd_in_data  = 8'h00;
        g_cmd_in_valid = 1'b0;
        g_cha_ready    = 1'b0;
        g_chb_ready    = 1'b1;
        test_reset();
        test_unicast_a();
        test_broadcast();
        test_full_backpressure();
        test_gap();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_chan_dispatch.md
# cmd_chan_dispatch

Command channel dispatcher: consumes latency-adjusted commands from the command-latency stage and routes each one to subchannel A, subchannel B, or both. Each subchannel has its own output FIFO and a minimum inter-command gap timer. It sits between the command-latency stage and the per-subchannel CA output drivers of the RCD.

## Interface
- DATA_WIDTH, 8: command width; bit [DATA_WIDTH-1] is subchannel select, bit [DATA_WIDTH-2] is broadcast.
- FIFO_DEPTH, 4: entries per subchannel FIFO; power of two, ≥2.
- MIN_GAP, 1: idle cycles forced on a subchannel after each output handshake; 0–15.
- LVL_W, $clog2(FIFO_DEPTH+1): width of the level outputs (derived).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_in_data  in  DATA_WIDTH  command from the latency stage.
- cmd_in_valid  in  1  command valid.
- cmd_in_ready  out  1  dispatcher can accept a command.
- cha_data / chb_data  out  DATA_WIDTH  subchannel A/B command, routing bits passed through unchanged.
- cha_par / chb_par  out  1  even parity over the cha_data / chb_data word.
- cha_valid / chb_valid  out  1  subchannel command valid.
- cha_ready / chb_ready  in  1  subchannel driver ready.
- cha_level / chb_level  out  LVL_W  FIFO occupancy.
- bcast_cnt  out  8  count of broadcast commands accepted; wraps at 255 to 0.

## Operation
- Routing:
  - Accept occurs when cmd_in_valid && cmd_in_ready.
  - Broadcast bit = 1: the command is written to both FIFOs in the same cycle (atomic), and bcast_cnt increments.
  - Broadcast bit = 0: select = 0 writes to FIFO A; select = 1 writes to FIFO B.
- cmd_in_ready = !fullA && !fullB. It is conservative, independent of cmd_in_data and of same-cycle pops. A full FIFO never accepts a write, even when that FIFO is popping in the same cycle.
- FIFOs: registered storage with read/write pointers of $clog2(FIFO_DEPTH)+1 bits.
  - Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - Pointers wrap naturally.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- Gap timer, one per subchannel, two states:
  - READY → HOLD on an output handshake (chX_valid && chX_ready) when MIN_GAP > 0. The counter loads MIN_GAP−1.
  - HOLD decrements each cycle. It returns to READY in the cycle after the counter reads 0.
  - chX_valid = !emptyX && state == READY.
  - MIN_GAP = 0: the timer stays in READY permanently.
- The two subchannels are fully independent after the write. Backpressure on one stalls input only when that FIFO fills.
- Reset mid-operation clears all FIFO contents, pointers, timers and bcast_cnt immediately. Commands in flight are discarded.

## Timing
- Reset values:
  - cmd_in_ready = 1.
  - cha_valid = chb_valid = 0.
  - cha_data = chb_data = 0, cha_par = chb_par = 0.
  - levels = 0, bcast_cnt = 0, both timers in READY.
- Latency: a command accepted at edge N is presented on chX_valid/chX_data after edge N; chX_valid is high in cycle N+1. No combinational path from cmd_in_* to chX_*.
- chX_data and chX_par come from the FIFO read pointer and are stable while chX_valid is high and not handshaken.
- Gap: with a handshake at edge N, chX_valid is low for cycles N+1 … N+MIN_GAP and may be high again from cycle N+MIN_GAP+1.
- Level updates take effect the cycle after the push/pop edge.

## Configuration
- CMD_DISPATCH_PARITY_EN:
  - Defined: cha_par / chb_par carry the XOR of all bits of cha_data / chb_data, computed from FIFO output (combinational from the registered read data).
  - Undefined: no parity logic is built and cha_par / chb_par are tied to 0.
- Port list is identical in both builds.

## Test plan
- Unicast A: with MIN_GAP = 0 and cha_ready = 1, send 0x05 then 0x06.
  - cha_valid is high in the cycles following each accept, with cha_data = 0x05 then 0x06.
  - chb_valid stays 0 and bcast_cnt = 0.
- Broadcast: send 0x41.
  - Both cha_valid and chb_valid assert in the same cycle with data 0x41, and bcast_cnt = 1.
  - With parity enabled, cha_par = chb_par = 0.
  - Then send 0x43: both channels present 0x43, par = 1 (when enabled), and bcast_cnt = 2.
- Full/backpressure: hold chb_ready = 0 and send 4 commands of 0x80.
  - chb_level = 4 and cmd_in_ready drops to 0.
  - A fifth command stays pending with no loss.
  - Raising chb_ready for one cycle restores cmd_in_ready the next cycle.
- Gap: with MIN_GAP = 3, preload 3 entries in A and hold cha_ready = 1.
  - Handshakes occur at cycles N, N+4 and N+8.
  - cha_valid is low in N+1 … N+3 and N+5 … N+7.
- Wrap and simultaneous push/pop: stream 20 commands into A with cha_ready = 1 and MIN_GAP = 0.
  - Output order matches input order and the level never exceeds 1.
  - Pointers wrap at least twice with no corruption.
- Reset mid-operation: with chb_level = 3, pulse rst_n low for 1 cycle.
  - Outputs immediately take reset values and bcast_cnt = 0.
  - The first command after reset is the first one output.
